// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex 7-segment driver.
// A packed hex value is latched into a shadow set. The shadow set moves to the
// displayed (active) set only at a frame boundary, so a frame never tears.
// Digits are scanned one at a time onto a shared segment bus with one-hot anodes.
// The output stage is registered and lags the scan state by one cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int LZ_BLANK       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic [6:0]                seg,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [2:0]                digit_idx,
  output logic                      frame_start
);

  localparam int                    DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]            IDX_LAST = 3'(NUM_DIGITS - 1);
  // Inactive levels; XOR-ing an active-high pattern with these applies polarity.
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  // Hex nibble to active-high {a,b,c,d,e,f,g} pattern.
  function automatic logic [6:0] seg7_enc(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b1111110;
      4'h1: pat = 7'b0110000;
      4'h2: pat = 7'b1101101;
      4'h3: pat = 7'b1111001;
      4'h4: pat = 7'b0110011;
      4'h5: pat = 7'b1011011;
      4'h6: pat = 7'b1011111;
      4'h7: pat = 7'b1110000;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1110011;
      4'ha: pat = 7'b1110111;
      4'hb: pat = 7'b0011111;
      4'hc: pat = 7'b1001110;
      4'hd: pat = 7'b0111101;
      4'he: pat = 7'b1001111;
      4'hf: pat = 7'b1000111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  logic [DIV_W-1:0]        div_cnt_r;
  logic [2:0]              idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_val_r, act_val_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, act_dp_r;
  logic [NUM_DIGITS-1:0]   shadow_blank_r, act_blank_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [2:0]              digit_idx_r;
  logic                    frame_start_r;

  logic                    tick_s;
  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic                    dp_bit_s;
  logic                    blank_bit_s;
  logic [NUM_DIGITS-1:0]   hot_s;
  logic                    upper_nz_s;
  logic                    dark_s;

  assign tick_s = (div_cnt_r == DIV_LAST);
  assign wrap_s = tick_s && (idx_r == IDX_LAST);

  // Select the current digit's data and check whether it or any higher nibble is non-zero.
  always_comb begin
    nib_s       = 4'h0;
    dp_bit_s    = 1'b0;
    blank_bit_s = 1'b0;
    hot_s       = {NUM_DIGITS{1'b0}};
    upper_nz_s  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_s       = (idx_r == 3'(i)) ? act_val_r[4*i +: 4] : nib_s;
      dp_bit_s    = (idx_r == 3'(i)) ? act_dp_r[i]         : dp_bit_s;
      blank_bit_s = (idx_r == 3'(i)) ? act_blank_r[i]      : blank_bit_s;
      hot_s[i]    = (idx_r == 3'(i));
      upper_nz_s  = upper_nz_s | ((3'(i) >= idx_r) && (act_val_r[4*i +: 4] != 4'h0));
    end
    // Digit 0 is never treated as a leading zero.
    dark_s = !enable || blank_bit_s ||
             ((LZ_BLANK != 0) && (idx_r != 3'd0) && !upper_nz_s);
  end

  // Refresh divider and digit scan index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      idx_r     <= 3'd0;
    end else begin
      div_cnt_r <= tick_s ? {DIV_W{1'b0}} : div_cnt_r + 1'b1;
      if (tick_s) begin
        idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
      end
    end
  end

  // Shadow capture on every load strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val_r   <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r    <= {NUM_DIGITS{1'b0}};
      shadow_blank_r <= {NUM_DIGITS{1'b0}};
    end else if (load) begin
      shadow_val_r   <= value;
      shadow_dp_r    <= dp_in;
      shadow_blank_r <= blank_in;
    end
  end

  // Active set updates only at the frame boundary; a load on that edge bypasses the shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_val_r   <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r    <= {NUM_DIGITS{1'b0}};
      act_blank_r <= {NUM_DIGITS{1'b0}};
    end else if (wrap_s) begin
      act_val_r   <= load ? value    : shadow_val_r;
      act_dp_r    <= load ? dp_in    : shadow_dp_r;
      act_blank_r <= load ? blank_in : shadow_blank_r;
    end
  end

  // Registered output stage: drive the digit selected last cycle, with polarity applied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r         <= SEG_OFF;
      dp_r          <= DP_OFF;
      an_r          <= AN_OFF;
      digit_idx_r   <= 3'd0;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= dark_s ? SEG_OFF : (seg7_enc(nib_s) ^ SEG_OFF);
      dp_r          <= dark_s ? DP_OFF  : (dp_bit_s ^ DP_OFF);
      an_r          <= dark_s ? AN_OFF  : (hot_s ^ AN_OFF);
      digit_idx_r   <= idx_r;
      frame_start_r <= (idx_r == 3'd0) && (div_cnt_r == {DIV_W{1'b0}});
    end
  end

  assign seg         = seg_r;
  assign dp_out      = dp_r;
  assign an          = an_r;
  assign digit_idx   = digit_idx_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero suppression off/on)
// share one set of inputs. The reference model derives every output from the
// count of edges since reset and a log of loads, using frame arithmetic.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic [3:0] an0, an1;
  logic [2:0] di0, di1;
  logic       fs0, fs1;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .LZ_BLANK(0),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg0), .dp_out(dp0), .an(an0),
    .digit_idx(di0), .frame_start(fs0));

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_in(blank_in), .seg(seg1), .dp_out(dp1), .an(an1),
    .digit_idx(di1), .frame_start(fs1));

  always #5 clk = ~clk;

  logic [6:0] enc_tab [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  typedef struct {
    int          edge_n;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } load_t;

  load_t loads[$];
  int    k = 0;
  bit    en_last = 1'b0;
  bit    ready = 1'b0;
  int    n_vec = 0;
  int    n_miss = 0;

  // Model bookkeeping: count edges since reset release, log loads and sampled enable.
  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      loads.delete();
      en_last = 1'b0;
    end else begin
      k = k + 1;
      en_last = enable;
      if (load) loads.push_back('{k, value, dp_in, blank_in});
    end
    ready = 1'b1;
  end

  // Expected outputs after edge k: scan state as of edge k-1, contents from the
  // last frame boundary at or before edge k-1, enable as sampled on edge k.
  task automatic model(input bit lz, output logic [6:0] s, output logic d,
                       output logic [3:0] a, output logic [2:0] di, output logic fs);
    int m, idx, b;
    logic [15:0] v;
    logic [3:0]  dp, bl;
    bit dark, upz;
    s = 7'b0; d = 1'b0; a = 4'hf; di = 3'd0; fs = 1'b0;
    if (k == 0) return;
    m = k - 1;
    idx = (m / RD) % ND;
    b = (m / FR) * FR;
    v = 16'h0; dp = 4'h0; bl = 4'h0;
    if (b > 0) begin
      for (int j = loads.size() - 1; j >= 0; j--) begin
        if (loads[j].edge_n <= b) begin
          v = loads[j].v; dp = loads[j].dp; bl = loads[j].bl;
          break;
        end
      end
    end
    di = 3'(idx);
    fs = (m % FR == 0);
    upz = ((v >> (4 * idx)) == 16'h0);
    dark = !en_last || bl[idx] || (lz && idx != 0 && upz);
    if (!dark) begin
      s = enc_tab[v[4*idx +: 4]];
      d = dp[idx];
      a = ~(4'b0001 << idx);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, k);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [6:0] es;
    logic       ed, efs;
    logic [3:0] ea;
    logic [2:0] edi;
    if (ready) begin
      model(1'b0, es, ed, ea, edi, efs);
      chk("u0.seg", 32'(seg0), 32'(es));
      chk("u0.dp", 32'(dp0), 32'(ed));
      chk("u0.an", 32'(an0), 32'(ea));
      chk("u0.digit_idx", 32'(di0), 32'(edi));
      chk("u0.frame_start", 32'(fs0), 32'(efs));
      model(1'b1, es, ed, ea, edi, efs);
      chk("u1.seg", 32'(seg1), 32'(es));
      chk("u1.dp", 32'(dp1), 32'(ed));
      chk("u1.an", 32'(an1), 32'(ea));
      chk("u1.digit_idx", 32'(di1), 32'(edi));
      chk("u1.frame_start", 32'(fs1), 32'(efs));
    end
  end

  // Advance to the falling edge that follows edge number t, with a cycle budget.
  task automatic wait_k(input int t);
    int n = 0;
    while (k != t && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (k != t) begin
      n_vec = n_vec + 1;
      n_miss = n_miss + 1;
      $display("FAIL wait_k: reached edge %0d expected %0d", k, t);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.an", 32'(an0), 32'(4'hf));
    chk("rst.seg", 32'(seg0), 32'(7'h00));
    chk("rst.dp", 32'(dp0), 32'(1'b0));
    chk("rst.digit_idx", 32'(di0), 32'(3'd0));
    chk("rst.frame_start", 32'(fs0), 32'(1'b0));

    // Load 1234 on the first edge; first frame still shows zeros.
    rst_n = 1'b1; load = 1'b1; value = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
    @(negedge clk); load = 1'b0;
    wait_k(17);
    chk("lit.d0.an", 32'(an0), 32'(4'b1110));
    chk("lit.d0.seg", 32'(seg0), 32'(7'b0110011));
    chk("lit.d0.fs", 32'(fs0), 32'(1'b1));
    wait_k(29);
    chk("lit.d3.an", 32'(an0), 32'(4'b0111));
    chk("lit.d3.seg", 32'(seg0), 32'(7'b0110000));

    // Mid-frame load of 0070: current frame keeps 1234.
    load = 1'b1; value = 16'h0070;
    @(negedge clk); load = 1'b0;
    wait_k(31);
    chk("midload.seg", 32'(seg0), 32'(7'b0110000));
    wait_k(33);
    chk("lz.d0.seg", 32'(seg1), 32'(7'b1111110));
    chk("lz.d0.an", 32'(an1), 32'(4'b1110));
    wait_k(37);
    chk("lz.d1.seg", 32'(seg1), 32'(7'b1110000));
    wait_k(41);
    chk("lz.d2.an", 32'(an1), 32'(4'b1111));
    chk("lz.d2.seg", 32'(seg1), 32'(7'h00));
    chk("nolz.d2.an", 32'(an0), 32'(4'b1011));
    wait_k(45);
    chk("lz.d3.an", 32'(an1), 32'(4'b1111));

    // Value zero with suppression: only digit 0 lit.
    load = 1'b1; value = 16'h0000;
    @(negedge clk); load = 1'b0;
    wait_k(49);
    chk("zero.d0.an", 32'(an1), 32'(4'b1110));
    chk("zero.d0.seg", 32'(seg1), 32'(7'b1111110));
    wait_k(53);
    chk("zero.d1.an", 32'(an1), 32'(4'b1111));

    // ABCD with decimal point on digit 1.
    load = 1'b1; value = 16'habcd; dp_in = 4'b0010;
    @(negedge clk); load = 1'b0;
    wait_k(65);
    chk("abcd.d0.seg", 32'(seg0), 32'(7'b0111101));
    chk("abcd.d0.dp", 32'(dp0), 32'(1'b0));
    wait_k(69);
    chk("abcd.d1.seg", 32'(seg0), 32'(7'b1001110));
    chk("abcd.d1.dp", 32'(dp0), 32'(1'b1));
    chk("abcd.d1.an", 32'(an0), 32'(4'b1101));
    wait_k(73);
    chk("abcd.d2.seg", 32'(seg0), 32'(7'b0011111));

    // Enable low for 10 cycles.
    enable = 1'b0;
    @(negedge clk);
    chk("dis.an", 32'(an0), 32'(4'b1111));
    chk("dis.seg", 32'(seg0), 32'(7'h00));
    repeat (9) @(negedge clk);
    enable = 1'b1;
    wait_k(84);
    chk("reen.an", 32'(an0), 32'(4'b1110));
    chk("reen.seg", 32'(seg0), 32'(7'b0111101));

    // Reset during the digit-2 window.
    wait_k(90);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.an", 32'(an0), 32'(4'hf));
    chk("midrst.digit_idx", 32'(di0), 32'(3'd0));
    chk("midrst.frame_start", 32'(fs0), 32'(1'b0));
    rst_n = 1'b1;

    // Randomized phase: rare resets, occasional enable drops, sparse blanking, zero-biased nibbles.
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(0, 499) != 0);
      enable = ($urandom_range(0, 19) != 0);
      load   = ($urandom_range(0, 9) == 0);
      for (int n = 0; n < 4; n++) begin
        value[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      dp_in    = 4'($urandom_range(0, 15));
      blank_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    load = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
